// File: rtl/game_pkg.sv
// Shared types and constants for the game screen overlay blocks.
// Click FSM encoding, coordinate widths and rectangle geometry bundle.
package game_pkg;

  localparam int COORD_W = 12;
  localparam int GEOM_W  = 11;
  localparam int DEFAULT_HOLDOFF = 16;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_ARMED       = 2'd1;
  localparam logic [1:0] ST_PRESSED_OUT = 2'd2;
  localparam logic [1:0] ST_HOLDOFF     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE        = ST_IDLE,
    S_ARMED       = ST_ARMED,
    S_PRESSED_OUT = ST_PRESSED_OUT,
    S_HOLDOFF     = ST_HOLDOFF
  } click_state_t;

  typedef struct packed {
    logic [GEOM_W-1:0] hstart;
    logic [GEOM_W-1:0] vstart;
    logic [GEOM_W-1:0] hlength;
    logic [GEOM_W-1:0] vlength;
  } rect_t;

  // Exclusive end; one extra bit so start+len never wraps.
  function automatic logic [COORD_W-1:0] rect_end(
    input logic [GEOM_W-1:0] start,
    input logic [GEOM_W-1:0] len
  );
    return {1'b0, start} + {1'b0, len};
  endfunction

endpackage

// File: rtl/rect_hit_test.sv
// Combinational point-in-rectangle test, half-open on both axes.
// A zero length on either axis never hits.
module rect_hit_test
  import game_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  rect_t              rect,
  output logic               hit
);

  logic [COORD_W-1:0] hend;
  logic [COORD_W-1:0] vend;
  logic               h_in;
  logic               v_in;

  assign hend = rect_end(rect.hstart, rect.hlength);
  assign vend = rect_end(rect.vstart, rect.vlength);

  assign h_in = (x >= {1'b0, rect.hstart}) && (x < hend);
  assign v_in = (y >= {1'b0, rect.vstart}) && (y < vend);

  assign hit = h_in && v_in;

endmodule

// File: rtl/rect_click_detector.sv
// Mouse click detector for a clickable rectangle: press and release
// inside gives rect_clicked, any accepted release gives any_clicked.
module rect_click_detector
  import game_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = DEFAULT_HOLDOFF
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  input  logic               mouse_left,
  input  logic [GEOM_W-1:0]  hstart,
  input  logic [GEOM_W-1:0]  vstart,
  input  logic [GEOM_W-1:0]  hlength,
  input  logic [GEOM_W-1:0]  vlength,
  output logic               rect_clicked,
  output logic               any_clicked,
  output logic               hover
);

  localparam int CNT_W =
    (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               left_q;
  logic               left_qq;
  logic               press;
  logic               rel;
  logic               hit;
  rect_t              rect;
  click_state_t       state;
  logic [CNT_W-1:0]   cnt;

  assign rect = '{
    hstart:  hstart,
    vstart:  vstart,
    hlength: hlength,
    vlength: vlength
  };

  // Button regs reset high: a button held across reset is not a press.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      left_q  <= 1'b1;
      left_qq <= 1'b1;
    end else begin
      x_q     <= xpos;
      y_q     <= ypos;
      left_q  <= mouse_left;
      left_qq <= left_q;
    end
  end

  assign press = left_q & ~left_qq;
  assign rel   = ~left_q & left_qq;

  rect_hit_test u_hit (
    .x    (x_q),
    .y    (y_q),
    .rect (rect),
    .hit  (hit)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rect_clicked <= 1'b0;
      any_clicked  <= 1'b0;
      hover        <= 1'b0;
    end else begin
      rect_clicked <= 1'b0;
      any_clicked  <= 1'b0;
      hover        <= hit;
      if (!enable) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (press)
              state <= hit ? S_ARMED : S_PRESSED_OUT;
          end
          S_ARMED: begin
            if (rel) begin
              any_clicked <= 1'b1;
              if (hit) begin
                rect_clicked <= 1'b1;
                if (HOLDOFF_CYCLES > 0) begin
                  state <= S_HOLDOFF;
                  cnt   <= HOLD_LOAD;
                end else begin
                  state <= S_IDLE;
                end
              end else begin
                state <= S_IDLE;
              end
            end else if (!hit) begin
              state <= S_PRESSED_OUT;
            end
          end
          S_PRESSED_OUT: begin
            if (rel) begin
              any_clicked <= 1'b1;
              state       <= S_IDLE;
            end
          end
          S_HOLDOFF: begin
            if (cnt == '0)
              state <= S_IDLE;
            else
              cnt <= cnt - 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/rect_click_detector.md
# rect_click_detector

Turns raw mouse position and left-button level into clean, single-cycle click events for the menu and score screens. Sits directly upstream of the game state machine: it takes the clickable rectangle geometry that the state machine drives (hstart/vstart/hlength/vlength) and feeds back `rect_clicked` (used as `rect_clicked_play`) and `any_clicked` (used as `mouse_clicked_stop`). A click counts only when the button is both pressed and released inside the rectangle, followed by a hold-off window that swallows bounce and double clicks.

## Interface
- `HOLDOFF_CYCLES`, 16: cycles after a rect click during which new presses are ignored; 0 disables hold-off.
- `pclk`  in  1  pixel clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  detection enabled; low forces IDLE.
- `xpos`, `ypos`  in  12 each  mouse position from the mouse controller.
- `mouse_left`  in  1  left button level, 1 = pressed.
- `hstart`, `vstart`, `hlength`, `vlength`  in  11 each  clickable rectangle.
- `rect_clicked`  out  1  one-cycle pulse: press and release both inside the rectangle.
- `any_clicked`  out  1  one-cycle pulse on every accepted release, anywhere.
- `hover`  out  1  registered level: pointer is inside the rectangle.

## Operation
- Input stage: `xpos`, `ypos`, `mouse_left` registered into `_q`; `mouse_left` also delayed into `left_qq`. Press edge = `left_q & ~left_qq`; release edge = `~left_q & left_qq`.
- Hit test uses registered position and live geometry: `hstart <= x < hstart+hlength` and `vstart <= y < vstart+vlength`. Sums are 12-bit, so there is no wrap. `hlength==0` or `vlength==0` means never hit.
- FSM states: IDLE, ARMED, PRESSED_OUT, HOLDOFF.
  - IDLE: press & hit -> ARMED; press & !hit -> PRESSED_OUT.
  - ARMED: release & hit -> pulse `rect_clicked` and `any_clicked`, then HOLDOFF (or IDLE if `HOLDOFF_CYCLES==0`). Release & !hit -> pulse `any_clicked`, then IDLE. Still held & !hit -> PRESSED_OUT; dragging off cancels the click.
  - PRESSED_OUT: release -> pulse `any_clicked`, then IDLE. Dragging back inside does not re-arm.
  - HOLDOFF: counter loads `HOLDOFF_CYCLES-1` and decrements each cycle. At 0 -> IDLE. Edges in HOLDOFF are ignored, including releases, so `any_clicked` stays low.
- `enable` low: next state is IDLE, counter cleared, pulses suppressed. `hover` is still computed.
- Geometry changes mid-press take effect on the next hit evaluation.

## Timing
- Reset values:
  - `rect_clicked=0`, `any_clicked=0`, `hover=0`, state IDLE, counter 0.
  - `left_q=left_qq=1`, so a button already held at reset release generates no press edge.
- Latency: a release sampled at edge k drives the pulse high from edge k+2 for exactly one cycle. `hover` lags the position by 2 cycles.
- Pulses never exceed one cycle. There are no back-to-back `rect_clicked` pulses closer than `HOLDOFF_CYCLES+2` cycles.
- Asserting `rst_n` low mid-operation immediately zeroes all outputs and returns to IDLE.

## Structure
- Shared package `game_pkg`: FSM state encoding (2-bit localparams), `DEFAULT_HOLDOFF=16`, coordinate width constants (`COORD_W=12`, `GEOM_W=11`).
- One natural sub-module: `rect_hit_test`, a combinational bounds comparator (position and geometry in, hit out). It is reused by other overlay blocks.
- Top level holds the input registers, edge detect, FSM, hold-off counter and output registers.

## Test plan
Common geometry for all scenarios: rect (492, 376, 300, 100), i.e. x 492..791, y 376..475.
- Press and release at (500, 400) -> `rect_clicked` and `any_clicked` high for one cycle, 2 cycles after the release edge; `hover=1`.
- Boundaries, each pressed and released at the point: (791, 475) -> `rect_clicked`; (792, 400) and (600, 476) -> only `any_clicked`.
- Press at (500, 400), drag to (800, 400), drag back to (500, 400), release -> no `rect_clicked`, one `any_clicked`.
- Set `hlength=0`, click at (492, 376) -> no `rect_clicked`, `hover=0`.
- Two rect clicks 10 cycles apart -> second ignored, no pulses. Repeat with the second click 30 cycles after the first -> second produces `rect_clicked`.
- `rst_n` low while ARMED -> outputs 0 asynchronously. Button held through reset release, then released -> no pulses. Next full click is accepted.
